// File: rtl/unit_control.sv
// -----------------------------------------------------------------------------
// unit_control -- multicycle main control FSM for the Core Musa datapath.
//
// Walks every instruction through IF/ID/EX and then, depending on the opcode,
// MEM and/or WB before returning to IF. The opcode is captured on the ID->EX
// edge, and all decode after that point uses the captured copy.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   opcode    6-bit opcode from the instruction register
//   stage     current stage: 000 IF, 001 ID, 010 EX, 011 MEM, 100 WB
//   pcSrc     PC source: 00 PC+4, 01 branch, 10 jump, 11 stack (return)
//   PCWrite   PC write strobe, one cycle in the final stage of each instruction
//   regDst    1 = rd destination, 0 = rt destination
//   aluSrc    ALU B operand: 00 reg, 01 sign-ext imm, 10 zero-ext imm
//   aluOp     00 add, 01 subtract, 10 funct field, 11 logic op by opcode
//   memRead   data memory read strobe (MEM only)
//   memWrite  data memory write strobe (MEM only)
//   memToReg  write-back data from memory (1) or ALU (0)
//   regWrite  register file write strobe (WB only)
//   push      stack push strobe (MEM only)
//   pop       stack pop strobe (MEM only)
// -----------------------------------------------------------------------------
module unit_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic [2:0] stage,
  output logic [1:0] pcSrc,
  output logic       PCWrite,
  output logic       regDst,
  output logic [1:0] aluSrc,
  output logic [1:0] aluOp,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       regWrite,
  output logic       push,
  output logic       pop
);

  typedef enum logic [2:0] {
    stIf  = 3'b000,
    stId  = 3'b001,
    stEx  = 3'b010,
    stMem = 3'b011,
    stWb  = 3'b100
  } stageT;

  localparam logic [5:0] opRtype  = 6'b000000;
  localparam logic [5:0] opRext   = 6'b011100;
  localparam logic [5:0] opAddi   = 6'b001000;
  localparam logic [5:0] opAddiu  = 6'b001001;
  localparam logic [5:0] opAndi   = 6'b001100;
  localparam logic [5:0] opOri    = 6'b001101;
  localparam logic [5:0] opLw     = 6'b100011;
  localparam logic [5:0] opSw     = 6'b101011;
  localparam logic [5:0] opBeq    = 6'b000100;
  localparam logic [5:0] opBne    = 6'b000101;
  localparam logic [5:0] opJmp    = 6'b000010;
  localparam logic [5:0] opCall   = 6'b000011;
  localparam logic [5:0] opPush   = 6'b010001;
  localparam logic [5:0] opPop    = 6'b000001;
  localparam logic [5:0] opRet    = 6'b000111;

  // Per-opcode settings: which optional stages follow EX, plus the controls.
  typedef struct packed {
    logic       hasMem;
    logic       hasWb;
    logic [1:0] pcSrc;
    logic       regDst;
    logic [1:0] aluSrc;
    logic [1:0] aluOp;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic       push;
    logic       pop;
  } ctrlT;

  function automatic ctrlT decodeOp(input logic [5:0] op);
    ctrlT c;
    c = '0;
    case (op)
      opRtype, opRext: begin
        c.hasWb = 1'b1; c.regDst = 1'b1; c.aluOp = 2'b10;
      end
      opAddi, opAddiu: begin
        c.hasWb = 1'b1; c.aluSrc = 2'b01;
      end
      opAndi, opOri: begin
        c.hasWb = 1'b1; c.aluSrc = 2'b10; c.aluOp = 2'b11;
      end
      opLw: begin
        c.hasMem = 1'b1; c.hasWb = 1'b1; c.aluSrc = 2'b01;
        c.memRead = 1'b1; c.memToReg = 1'b1;
      end
      opSw: begin
        c.hasMem = 1'b1; c.aluSrc = 2'b01; c.memWrite = 1'b1;
      end
      opBeq, opBne: begin
        c.aluOp = 2'b01; c.pcSrc = 2'b01;
      end
      opJmp:  c.pcSrc = 2'b10;
      opCall: begin
        c.hasMem = 1'b1; c.push = 1'b1; c.memWrite = 1'b1; c.pcSrc = 2'b10;
      end
      opPush: begin
        c.hasMem = 1'b1; c.push = 1'b1; c.memWrite = 1'b1;
      end
      opPop: begin
        c.hasMem = 1'b1; c.hasWb = 1'b1; c.pop = 1'b1;
        c.memRead = 1'b1; c.memToReg = 1'b1;
      end
      opRet: begin
        c.hasMem = 1'b1; c.pop = 1'b1; c.memRead = 1'b1; c.pcSrc = 2'b11;
      end
      default: c = '0;  // NOP: IF, ID, EX with everything at zero
    endcase
    return c;
  endfunction

  stageT      stageQ;
  stageT      nextStage;
  logic [5:0] opLatch;
  logic [5:0] curOp;
  ctrlT       dec;

  logic [1:0] nxPcSrc;
  logic       nxPCWrite;
  logic       nxRegDst;
  logic [1:0] nxAluSrc;
  logic [1:0] nxAluOp;
  logic       nxMemRead;
  logic       nxMemWrite;
  logic       nxMemToReg;
  logic       nxRegWrite;
  logic       nxPush;
  logic       nxPop;

  // Outputs are registered, so they are computed for the stage being entered.
  // On the ID->EX edge the latch is only just loading, so decode looks at the
  // live opcode there; everywhere else it uses the captured copy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    curOp      = (stageQ == stId) ? opcode : opLatch;
    dec        = decodeOp(curOp);
    nextStage  = stIf;
    nxPcSrc    = 2'b00;
    nxPCWrite  = 1'b0;
    nxRegDst   = 1'b0;
    nxAluSrc   = 2'b00;
    nxAluOp    = 2'b00;
    nxMemRead  = 1'b0;
    nxMemWrite = 1'b0;
    nxMemToReg = 1'b0;
    nxRegWrite = 1'b0;
    nxPush     = 1'b0;
    nxPop      = 1'b0;

    case (stageQ)
      stIf:    nextStage = stId;
      stId:    nextStage = stEx;
      stEx:    nextStage = dec.hasMem ? stMem : (dec.hasWb ? stWb : stIf);
      stMem:   nextStage = dec.hasWb ? stWb : stIf;
      default: nextStage = stIf;  // WB and the unused codes 101..111
    endcase

    if (nextStage == stEx || nextStage == stMem || nextStage == stWb) begin
      nxPcSrc    = dec.pcSrc;
      nxRegDst   = dec.regDst;
      nxAluSrc   = dec.aluSrc;
      nxAluOp    = dec.aluOp;
      nxMemToReg = dec.memToReg;
    end

    if (nextStage == stMem) begin
      nxMemRead  = dec.memRead;
      nxMemWrite = dec.memWrite;
      nxPush     = dec.push;
      nxPop      = dec.pop;
    end

    nxRegWrite = (nextStage == stWb);

    // The stage being entered is the last one when nothing follows it.
    case (nextStage)
      stEx:    nxPCWrite = !dec.hasMem && !dec.hasWb;
      stMem:   nxPCWrite = !dec.hasWb;
      stWb:    nxPCWrite = 1'b1;
      default: nxPCWrite = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stageQ   <= stIf;
      opLatch  <= 6'b000000;
      pcSrc    <= 2'b00;
      PCWrite  <= 1'b0;
      regDst   <= 1'b0;
      aluSrc   <= 2'b00;
      aluOp    <= 2'b00;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      memToReg <= 1'b0;
      regWrite <= 1'b0;
      push     <= 1'b0;
      pop      <= 1'b0;
    end else begin
      stageQ   <= nextStage;
      if (stageQ == stId) opLatch <= opcode;
      pcSrc    <= nxPcSrc;
      PCWrite  <= nxPCWrite;
      regDst   <= nxRegDst;
      aluSrc   <= nxAluSrc;
      aluOp    <= nxAluOp;
      memRead  <= nxMemRead;
      memWrite <= nxMemWrite;
      memToReg <= nxMemToReg;
      regWrite <= nxRegWrite;
      push     <= nxPush;
      pop      <= nxPop;
    end
  end

  assign stage = stageQ;

endmodule

// File: tb/tb_unit_control.sv
// -----------------------------------------------------------------------------
// tb_unit_control -- directed bench for unit_control.
//
// The stimulus process drives opcodes/reset and pushes the hand-computed
// output vector expected for each cycle into a scoreboard queue; the monitor
// pops and compares on every falling edge (or on an explicit sample event).
// -----------------------------------------------------------------------------
module tb_unit_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [2:0] stage;
  logic [1:0] pcSrc;
  logic       PCWrite;
  logic       regDst;
  logic [1:0] aluSrc;
  logic [1:0] aluOp;
  logic       memRead;
  logic       memWrite;
  logic       memToReg;
  logic       regWrite;
  logic       push;
  logic       pop;

  unit_control dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .stage    (stage),
    .pcSrc    (pcSrc),
    .PCWrite  (PCWrite),
    .regDst   (regDst),
    .aluSrc   (aluSrc),
    .aluOp    (aluOp),
    .memRead  (memRead),
    .memWrite (memWrite),
    .memToReg (memToReg),
    .regWrite (regWrite),
    .push     (push),
    .pop      (pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] stage;
    logic [1:0] pcSrc;
    logic       PCWrite;
    logic       regDst;
    logic [1:0] aluSrc;
    logic [1:0] aluOp;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regWrite;
    logic       push;
    logic       pop;
  } outV;

  typedef struct {
    outV   exp;
    string tag;
  } sbEntry;

  sbEntry sb[$];
  outV    plan[$];
  int     nTests = 0;
  int     nFail  = 0;
  event   smp;

  function automatic outV v(input logic [2:0] st, input logic [1:0] ps,
                            input logic pw, input logic rd,
                            input logic [1:0] as, input logic [1:0] ao,
                            input logic mr, input logic mw, input logic m2r,
                            input logic rw, input logic pu, input logic po);
    outV r;
    r = {st, ps, pw, rd, as, ao, mr, mw, m2r, rw, pu, po};
    return r;
  endfunction

  localparam outV vIf = '0;
  localparam outV vId = 17'b001_00_0_0_00_00_000000;

  task automatic expectNow(input outV e, input string tag);
    sbEntry s;
    s.exp = e;
    s.tag = tag;
    sb.push_back(s);
  endtask

  task automatic step(input outV e, input string tag);
    @(posedge clk);
    #1;
    expectNow(e, tag);
  endtask

  // Runs the current plan for one instruction starting from IF, optionally
  // switching the opcode input right after plan entry chgIdx is entered,
  // then steps back into IF.
  task automatic runPlan(input logic [5:0] op, input string tag,
                         input int chgIdx, input logic [5:0] chgOp);
    opcode = op;
    for (int i = 0; i < plan.size(); i++) begin
      step(plan[i], $sformatf("%s.s%0d", tag, i + 1));
      if (i == chgIdx) opcode = chgOp;
    end
    step(vIf, {tag, ".ret_if"});
    plan.delete();
  endtask

  // Monitor
  initial begin
    sbEntry e;
    outV    got;
    forever begin
      @(negedge clk or smp);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {stage, pcSrc, PCWrite, regDst, aluSrc, aluOp,
               memRead, memWrite, memToReg, regWrite, push, pop};
        nTests++;
        if (got !== e.exp) begin
          nFail++;
          $display("FAIL %s: got stg=%b pcSrc=%b pcw=%b rd=%b as=%b ao=%b mr/mw/m2r/rw/pu/po=%b, expected stg=%b pcSrc=%b pcw=%b rd=%b as=%b ao=%b mr/mw/m2r/rw/pu/po=%b",
                   e.tag, got.stage, got.pcSrc, got.PCWrite, got.regDst,
                   got.aluSrc, got.aluOp, got[5:0], e.exp.stage, e.exp.pcSrc,
                   e.exp.PCWrite, e.exp.regDst, e.exp.aluSrc, e.exp.aluOp,
                   e.exp[5:0]);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    reset  = 1'b1;
    opcode = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    expectNow(vIf, "reset_hold");
    @(posedge clk);
    #1;
    reset = 1'b0;
    expectNow(vIf, "reset_release_if");

    // R-type
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b00, 0, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0));
    plan.push_back(v(3'd4, 2'b00, 1, 1, 2'b00, 2'b10, 0, 0, 0, 1, 0, 0));
    runPlan(6'b000000, "rtype", -1, 6'b000000);

    // LW
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0));
    plan.push_back(v(3'd3, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 1, 0, 0, 0));
    plan.push_back(v(3'd4, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0, 1, 1, 0, 0));
    runPlan(6'b100011, "lw", -1, 6'b000000);

    // SW then BNE
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    plan.push_back(v(3'd3, 2'b00, 1, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0));
    runPlan(6'b101011, "sw", -1, 6'b000000);
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b01, 1, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0));
    runPlan(6'b000101, "bne", -1, 6'b000000);

    // CALL, JMP, PUSH, POP, RET
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b10, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    plan.push_back(v(3'd3, 2'b10, 1, 0, 2'b00, 2'b00, 0, 1, 0, 0, 1, 0));
    runPlan(6'b000011, "call", -1, 6'b000000);
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b10, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    runPlan(6'b000010, "jmp", -1, 6'b000000);
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    plan.push_back(v(3'd3, 2'b00, 1, 0, 2'b00, 2'b00, 0, 1, 0, 0, 1, 0));
    runPlan(6'b010001, "push", -1, 6'b000000);
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0));
    plan.push_back(v(3'd3, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0, 1));
    plan.push_back(v(3'd4, 2'b00, 1, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0));
    runPlan(6'b000001, "pop", -1, 6'b000000);
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b11, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    plan.push_back(v(3'd3, 2'b11, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1));
    runPlan(6'b000111, "ret", -1, 6'b000000);

    // ADDI, R-type extended, unknown opcode (NOP)
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    plan.push_back(v(3'd4, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0));
    runPlan(6'b001000, "addi", -1, 6'b000000);
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b00, 0, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0));
    plan.push_back(v(3'd4, 2'b00, 1, 1, 2'b00, 2'b10, 0, 0, 0, 1, 0, 0));
    runPlan(6'b011100, "rext", -1, 6'b000000);
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b00, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    runPlan(6'b111111, "nop", -1, 6'b000000);

    // LW with opcode switched to ANDI once in MEM, then the ANDI itself
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0));
    plan.push_back(v(3'd3, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 1, 0, 0, 0));
    plan.push_back(v(3'd4, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0, 1, 1, 0, 0));
    runPlan(6'b100011, "lw_chg", 2, 6'b001100);
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b00, 0, 0, 2'b10, 2'b11, 0, 0, 0, 0, 0, 0));
    plan.push_back(v(3'd4, 2'b00, 1, 0, 2'b10, 2'b11, 0, 0, 0, 1, 0, 0));
    runPlan(6'b001100, "andi", -1, 6'b001100);

    // Reset in the middle of LW's MEM stage
    opcode = 6'b100011;
    step(vId, "lwrst.id");
    step(v(3'd2, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0), "lwrst.ex");
    step(v(3'd3, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 1, 0, 0, 0), "lwrst.mem");
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    expectNow(vIf, "lwrst.async_reset");
    -> smp;
    step(vIf, "lwrst.held");
    reset = 1'b0;
    plan.push_back(vId);
    plan.push_back(v(3'd2, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0));
    plan.push_back(v(3'd3, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 1, 0, 0, 0));
    plan.push_back(v(3'd4, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0, 1, 1, 0, 0));
    runPlan(6'b100011, "lw_after_rst", -1, 6'b000000);

    repeat (2) @(negedge clk);
    #1;
    nTests++;
    if (sb.size() != 0) begin
      nFail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
